forward_ctrl: RTL and testbench
===============================

# forward_ctrl

Pipeline hazard controller that drives the select inputs of the EX-stage 3-to-1 operand multiplexers, one for ALU source A and one for source B. It tracks the destination tags of the instructions in EX and MEM in its own shadow registers. For the instruction leaving ID it registers a forwarding select and detects load-use hazards, raising a stall for one cycle. It sits beside the ID/EX pipeline register, and its select outputs are aligned with the instruction while that instruction is in EX.

## Interface
Parameters:
- REG_AW, 5: register-number width.
- CNT_W, 16: stall-counter width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- id_valid_i  in  1  the ID slot holds a real instruction.
- id_rs_i  in  REG_AW  source register A of the ID instruction.
- id_rt_i  in  REG_AW  source register B of the ID instruction.
- id_use_rs_i  in  1  the ID instruction reads rs.
- id_use_rt_i  in  1  the ID instruction reads rt.
- id_rd_i  in  REG_AW  destination register of the ID instruction.
- id_regwrite_i  in  1  the ID instruction writes rd.
- id_memread_i  in  1  the ID instruction is a load.
- flush_i  in  1  squash the ID instruction at this edge (taken branch).
- fwd_a_sel_o  out  2  mux select for source A: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.
- fwd_b_sel_o  out  2  same encoding, for source B.
- stall_o  out  1  combinational; hold PC and IF/ID at this edge.
- stall_count_o  out  CNT_W  number of stall cycles so far, saturating.

## Operation
State:
- EX slot: {valid, rd, regwrite, memread}.
- MEM slot: {valid, rd, regwrite}.
- Registered fwd_a_sel_o, fwd_b_sel_o.
- stall counter.

Producer definition:
- A slot is a producer of register r when valid & regwrite & rd == r & r != 0.
- Register 0 is never forwarded and never causes a stall.

Hazard and stall:
- haz = EX slot valid & memread & regwrite & EX rd != 0 & ((id_use_rs_i & id_rs_i == EX rd) | (id_use_rt_i & id_rt_i == EX rd)), gated by id_valid_i.
- stall_o = haz & ~flush_i.

Each rising edge, in priority order:
- flush_i = 1: EX slot <= bubble (valid = 0), MEM slot <= EX slot, both selects <= 0.
- else stall_o = 1: EX slot <= bubble, MEM slot <= EX slot, both selects <= 0, counter += 1 unless it is already all-ones.
- else: EX slot <= ID fields (valid = id_valid_i), MEM slot <= EX slot.
  - Select for source A: 1 if the current EX slot produces id_rs_i and id_use_rs_i = 1; otherwise 2 if the current MEM slot produces id_rs_i and id_use_rs_i = 1; otherwise 0.
  - Source B uses the same rule with id_rt_i and id_use_rt_i.
  - If id_valid_i = 0, both selects are 0.

Rules:
- When both slots produce the same register, the EX slot (the younger instruction) wins and the select is 1.
- A select value of 3 is never produced.
- The register file is write-first, so an instruction in WB needs no forwarding and is not tracked.

## Timing
- Reset (asynchronous, immediate):
  - both slots invalid;
  - fwd_a_sel_o = fwd_b_sel_o = 0;
  - stall_count_o = 0;
  - stall_o = 0, because the slots are invalid.
- Select latency: the ID fields presented in cycle n produce selects valid for the whole of cycle n+1, while that instruction is in EX.
- Stall latency: stall_o reflects the inputs of the same cycle, with no register in the path.
- Load-use sequence:
  - cycle n: the load is in EX and its consumer is in ID, so stall_o = 1.
  - cycle n+1: the consumer is still in ID; the EX slot is a bubble and the load is in the MEM slot, so stall_o = 0.
  - the edge ending n+1 registers select 2, which is valid in cycle n+2.
- A stall never lasts longer than one cycle per load.
- Simultaneous flush and hazard: flush wins. stall_o = 0 and the counter does not increment.
- When rst_i is asserted mid-stall, all state clears at once and the next edge after release behaves as from reset.

## Test plan
- Reset check: assert rst_i mid-run -> selects 0, stall_o 0, and stall_count_o 0 without waiting for a clock edge.
- EX forwarding: "add r3" followed by "sub r4,r3,r5" -> in the sub's EX cycle fwd_a_sel_o = 1, fwd_b_sel_o = 0.
- MEM forwarding and priority:
  - "add r3", then an independent op, then "or r6,r3,r3" -> fwd_a_sel_o = fwd_b_sel_o = 2.
  - Two consecutive writers of r3 followed by a reader -> select 1.
- Load-use: "lw r2", then "add r7,r2,r1" -> stall_o high for exactly one cycle, the add's EX cycle has fwd_a_sel_o = 2, and stall_count_o goes from 0 to 1.
- Register 0 and flush:
  - A writer of r0 followed by a reader of r0 -> selects 0 and no stall.
  - A load-use hazard with flush_i = 1 in the same cycle -> stall_o = 0, the counter does not change, and the next EX slot is a bubble.
- Counter saturation: with CNT_W = 2, four load-use stalls -> stall_count_o sticks at 3.

Source files
------------

// File: rtl/forward_ctrl.sv
// EX-stage operand forwarding select generation and load-use stall detection.
// Shadows the destination tags of the EX and MEM instructions.
module forward_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_count_o
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              mem_valid;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwrite;

    logic              haz;
    logic [1:0]        sel_a_next;
    logic [1:0]        sel_b_next;

    function automatic logic producer(input logic valid, input logic regwrite,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] r);
        return valid & regwrite & (rd == r) & (r != REG_ZERO);
    endfunction

    // The younger EX producer takes precedence over the MEM producer.
    function automatic logic [1:0] pick_sel(input logic use_src, input logic ex_hit,
                                            input logic mem_hit);
        logic [1:0] sel;
        sel = 2'd0;
        if (use_src & ex_hit) begin
            sel = 2'd1;
        end else if (use_src & mem_hit) begin
            sel = 2'd2;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Load-use hazard detection and next forwarding selects for the ID instruction.
    always_comb begin
        haz        = 1'b0;
        stall_o    = 1'b0;
        sel_a_next = 2'd0;
        sel_b_next = 2'd0;
        haz = id_valid_i & ex_valid & ex_memread & ex_regwrite & (ex_rd != REG_ZERO) &
              ((id_use_rs_i & (id_rs_i == ex_rd)) | (id_use_rt_i & (id_rt_i == ex_rd)));
        stall_o = haz & ~flush_i;
        if (id_valid_i) begin
            sel_a_next = pick_sel(id_use_rs_i,
                                  producer(ex_valid, ex_regwrite, ex_rd, id_rs_i),
                                  producer(mem_valid, mem_regwrite, mem_rd, id_rs_i));
            sel_b_next = pick_sel(id_use_rt_i,
                                  producer(ex_valid, ex_regwrite, ex_rd, id_rt_i),
                                  producer(mem_valid, mem_regwrite, mem_rd, id_rt_i));
        end else begin
            sel_a_next = 2'd0;
            sel_b_next = 2'd0;
        end
    end

    // Shadow EX/MEM slots and registered selects; flush and stall both insert a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid     <= 1'b0;
            ex_rd        <= REG_ZERO;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= REG_ZERO;
            mem_regwrite <= 1'b0;
            fwd_a_sel_o  <= 2'd0;
            fwd_b_sel_o  <= 2'd0;
        end else begin
            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            if (flush_i | stall_o) begin
                ex_valid    <= 1'b0;
                ex_rd       <= REG_ZERO;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                fwd_a_sel_o <= 2'd0;
                fwd_b_sel_o <= 2'd0;
            end else begin
                ex_valid    <= id_valid_i;
                ex_rd       <= id_rd_i;
                ex_regwrite <= id_regwrite_i;
                ex_memread  <= id_memread_i;
                fwd_a_sel_o <= sel_a_next;
                fwd_b_sel_o <= sel_b_next;
            end
        end
    end

    // Saturating count of stall cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_count_o <= {CNT_W{1'b0}};
        end else if (stall_o && (stall_count_o != CNT_MAX)) begin
            stall_count_o <= stall_count_o + CNT_ONE;
        end else begin
            stall_count_o <= stall_count_o;
        end
    end

endmodule

// File: tb/tb_forward_ctrl.sv
// Self-checking bench for forward_ctrl: directed hazard scenarios plus random
// instruction streams against a slot-level reference model.
module tb_forward_ctrl;

    logic       clk;
    logic       rst_i;
    logic       id_valid_i;
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic       id_use_rs_i;
    logic       id_use_rt_i;
    logic [4:0] id_rd_i;
    logic       id_regwrite_i;
    logic       id_memread_i;
    logic       flush_i;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic       stall;
    logic [15:0] cnt;
    logic [1:0] a_sel2;
    logic [1:0] b_sel2;
    logic       stall2;
    logic [1:0] cnt2;

    forward_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i),
        .id_rt_i(id_rt_i), .id_use_rs_i(id_use_rs_i), .id_use_rt_i(id_use_rt_i),
        .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .flush_i(flush_i), .fwd_a_sel_o(a_sel), .fwd_b_sel_o(b_sel),
        .stall_o(stall), .stall_count_o(cnt)
    );

    forward_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i),
        .id_rt_i(id_rt_i), .id_use_rs_i(id_use_rs_i), .id_use_rt_i(id_use_rt_i),
        .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .flush_i(flush_i), .fwd_a_sel_o(a_sel2), .fwd_b_sel_o(b_sel2),
        .stall_o(stall2), .stall_count_o(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
    } slot_t;

    slot_t m_ex, m_mem;
    int    m_a, m_b, m_cnt, m_cnt2;
    int    total = 0;
    int    bad   = 0;
    bit    st;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit produces(slot_t s, int r);
        return s.v && s.rw && s.rd == r && r != 0;
    endfunction

    function automatic int want_sel(bit v, bit use_src, int r);
        if (!v || !use_src) return 0;
        if (produces(m_ex, r)) return 1;
        if (produces(m_mem, r)) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_ex   = '{0, 0, 0, 0};
        m_mem  = '{0, 0, 0, 0};
        m_a    = 0;
        m_b    = 0;
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    // Reset is asserted away from any edge; outputs must clear immediately.
    task automatic do_reset();
        rst_i = 1'b1;
        id_valid_i = 1'b0;
        flush_i = 1'b0;
        #1;
        model_reset();
        check("rst_sel_a", a_sel, 0);
        check("rst_sel_b", b_sel, 0);
        check("rst_stall", stall, 0);
        check("rst_count", cnt, 0);
        check("rst_count_sat", cnt2, 0);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    // One ID-stage instruction for one cycle; checks stall before the edge and
    // selects/counters after it.
    task automatic issue(input bit v, input int rs, input int rt, input bit urs,
                         input bit urt, input int rd, input bit rw, input bit mr,
                         input bit fl, output bit st_seen);
        bit    hz, mst;
        slot_t nxt;
        id_valid_i    = v;
        id_rs_i       = rs[4:0];
        id_rt_i       = rt[4:0];
        id_use_rs_i   = urs;
        id_use_rt_i   = urt;
        id_rd_i       = rd[4:0];
        id_regwrite_i = rw;
        id_memread_i  = mr;
        flush_i       = fl;
        #2;
        hz  = v && m_ex.v && m_ex.mr && m_ex.rw && m_ex.rd != 0 &&
              ((urs && rs == m_ex.rd) || (urt && rt == m_ex.rd));
        mst = hz && !fl;
        st_seen = stall;
        check("stall", stall, mst);
        check("stall_sat", stall2, mst);
        @(posedge clk);
        if (fl || mst) begin
            m_a = 0;
            m_b = 0;
            nxt = '{0, 0, 0, 0};
            if (mst) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end else begin
            m_a = want_sel(v, urs, rs);
            m_b = want_sel(v, urt, rt);
            nxt = '{v, rd, rw, mr};
        end
        m_mem = m_ex;
        m_ex  = nxt;
        #1;
        check("sel_a", a_sel, m_a);
        check("sel_b", b_sel, m_b);
        check("sel_a_sat", a_sel2, m_a);
        check("sel_b_sat", b_sel2, m_b);
        check("count", cnt, m_cnt);
        check("count_sat", cnt2, m_cnt2);
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    endtask

    initial begin
        rst_i = 1'b1;
        id_valid_i = 1'b0; id_rs_i = 5'd0; id_rt_i = 5'd0; id_use_rs_i = 1'b0;
        id_use_rt_i = 1'b0; id_rd_i = 5'd0; id_regwrite_i = 1'b0;
        id_memread_i = 1'b0; flush_i = 1'b0;
        do_reset();

        // load-use: lw r2 ; add r7,r2,r1
        issue(1, 1, 0, 1, 0, 2, 1, 1, 0, st);
        issue(1, 2, 1, 1, 1, 7, 1, 0, 0, st);
        check("lu_stall_first", st, 1);
        check("lu_count_one", cnt, 1);
        issue(1, 2, 1, 1, 1, 7, 1, 0, 0, st);
        check("lu_stall_second", st, 0);
        check("lu_sel_a_mem", a_sel, 2);
        check("lu_sel_b", b_sel, 0);
        nop(); nop();

        // EX forwarding: add r3 ; sub r4,r3,r5
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0, st);
        issue(1, 3, 5, 1, 1, 4, 1, 0, 0, st);
        check("ex_fwd_a", a_sel, 1);
        check("ex_fwd_b", b_sel, 0);
        nop(); nop();

        // MEM forwarding: add r3 ; and r8,r1,r2 ; or r6,r3,r3
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0, st);
        issue(1, 1, 2, 1, 1, 8, 1, 0, 0, st);
        issue(1, 3, 3, 1, 1, 6, 1, 0, 0, st);
        check("mem_fwd_a", a_sel, 2);
        check("mem_fwd_b", b_sel, 2);
        nop(); nop();

        // Two writers of r3 then a reader: the younger wins
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0, st);
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0, st);
        issue(1, 3, 3, 1, 1, 9, 1, 0, 0, st);
        check("prio_a", a_sel, 1);
        check("prio_b", b_sel, 1);
        nop(); nop();

        // r0 is never forwarded nor a hazard, even from a load
        issue(1, 1, 0, 1, 0, 0, 1, 1, 0, st);
        issue(1, 0, 0, 1, 1, 5, 1, 0, 0, st);
        check("r0_no_stall", st, 0);
        check("r0_sel_a", a_sel, 0);
        check("r0_sel_b", b_sel, 0);
        nop(); nop();

        // Flush beats hazard; the flushed add r7 must not forward
        issue(1, 1, 0, 1, 0, 2, 1, 1, 0, st);
        issue(1, 2, 1, 1, 1, 7, 1, 0, 1, st);
        check("flush_no_stall", st, 0);
        check("flush_count_same", cnt, 1);
        issue(1, 7, 2, 1, 1, 10, 1, 0, 0, st);
        check("flush_bubble_a", a_sel, 0);
        check("flush_load_b", b_sel, 2);
        nop(); nop();

        // Counter saturation for the narrow instance
        do_reset();
        for (int k = 0; k < 4; k++) begin
            issue(1, 1, 0, 1, 0, 2, 1, 1, 0, st);
            issue(1, 2, 1, 1, 1, 7, 1, 0, 0, st);
            issue(1, 2, 1, 1, 1, 7, 1, 0, 0, st);
        end
        check("sat_count", cnt2, 3);
        check("wide_count", cnt, 4);

        // Reset asserted mid-stall with a live EX forward
        nop(); nop();
        issue(1, 4, 0, 1, 0, 1, 1, 0, 0, st);
        issue(1, 1, 0, 1, 0, 2, 1, 1, 0, st);
        check("pre_rst_sel_a", a_sel, 1);
        id_valid_i = 1'b1; id_rs_i = 5'd2; id_rt_i = 5'd1; id_use_rs_i = 1'b1;
        id_use_rt_i = 1'b1; id_rd_i = 5'd7; id_regwrite_i = 1'b1;
        id_memread_i = 1'b0; flush_i = 1'b0;
        #2;
        check("pre_rst_stall", stall, 1);
        do_reset();
        issue(1, 2, 1, 1, 1, 7, 1, 0, 0, st);
        check("post_rst_no_stall", st, 0);
        check("post_rst_sel_a", a_sel, 0);

        // Random stream over a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            issue($urandom_range(9, 0) < 8, $urandom_range(3, 0), $urandom_range(3, 0),
                  $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(3, 0),
                  $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0,
                  $urandom_range(9, 0) == 0, st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
